// File: rtl/uart_tx_engine_if.sv
// Processor-side port of the UART transmit engine: write strobe, byte and
// framing config in; serial line and ready indications out.
interface uart_tx_engine_if;
  logic       load;
  logic [7:0] out_port;
  logic       pen;
  logic       ohel;
  logic       tx;
  logic       tx_rdy;
  logic       tx_rdy_pulse;

  modport master (
    output load, out_port, pen, ohel,
    input  tx, tx_rdy, tx_rdy_pulse
  );

  modport slave (
    input  load, out_port, pen, ohel,
    output tx, tx_rdy, tx_rdy_pulse
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: frames one byte as start, 8 data bits LSB first,
// optional parity and stop on a registered serial line. Each completed frame
// produces a single-cycle tx_rdy_pulse for the downstream interrupt SR flop.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  IDLE   | line high, ready for a load strobe
//  START  | start bit (tx=0) for one bit time
//  DATA   | eight data bits, LSB first, one bit time each
//  PARITY | parity bit (only when pen was set at load)
//  STOP   | stop bit (tx=1); its last clock returns to IDLE with a pulse
module uart_tx_engine #(
  parameter int BAUD_DIV = 10416,
  parameter int CNT_W    = 14
) (
  input logic          clk,
  input logic          reset,
  uart_tx_engine_if.slave bus
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] baud_cnt, baud_n;
  logic [2:0]       bit_cnt, bit_n;
  logic [7:0]       shift_reg, shift_n;
  logic             pen_q, pen_n;
  logic             par_q, par_n;
  logic             tx_q, tx_n;
  logic             rdy_q, rdy_n;
  logic             pulse_q, pulse_n;
  logic             baud_wrap;

  assign baud_wrap = (baud_cnt == BAUD_LAST);

  // Next-state, counters and next registered output values.
  always_comb begin
    state_n = state;
    baud_n  = baud_wrap ? '0 : baud_cnt + 1'b1;
    bit_n   = bit_cnt;
    shift_n = shift_reg;
    pen_n   = pen_q;
    par_n   = par_q;
    tx_n    = tx_q;
    rdy_n   = rdy_q;
    pulse_n = 1'b0;

    case (state)
      IDLE: begin
        baud_n = '0;
        bit_n  = '0;
        tx_n   = 1'b1;
        rdy_n  = 1'b1;
        if (bus.load) begin
          // Parity is resolved at load so later port changes cannot leak in.
          shift_n = bus.out_port;
          pen_n   = bus.pen;
          par_n   = (^bus.out_port) ^ bus.ohel;
          state_n = START;
          tx_n    = 1'b0;
          rdy_n   = 1'b0;
        end
      end
      START: begin
        if (baud_wrap) begin
          state_n = DATA;
          tx_n    = shift_reg[0];
          shift_n = {1'b1, shift_reg[7:1]};
        end
      end
      DATA: begin
        if (baud_wrap) begin
          bit_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_n = pen_q ? PARITY : STOP;
            tx_n    = pen_q ? par_q : 1'b1;
          end else begin
            tx_n    = shift_reg[0];
            shift_n = {1'b1, shift_reg[7:1]};
          end
        end
      end
      PARITY: begin
        if (baud_wrap) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (baud_wrap) begin
          state_n = IDLE;
          tx_n    = 1'b1;
          rdy_n   = 1'b1;
          pulse_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
        rdy_n   = 1'b1;
      end
    endcase
  end

  // State and output registers; synchronous active-low reset wins over all.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift_reg <= '1;
      pen_q     <= 1'b0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      rdy_q     <= 1'b1;
      pulse_q   <= 1'b0;
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_n;
      shift_reg <= shift_n;
      pen_q     <= pen_n;
      par_q     <= par_n;
      tx_q      <= tx_n;
      rdy_q     <= rdy_n;
      pulse_q   <= pulse_n;
    end
  end

  assign bus.tx           = tx_q;
  assign bus.tx_rdy       = rdy_q;
  assign bus.tx_rdy_pulse = pulse_q;

endmodule
